spi_slave_fsm: RTL
==================

# spi_slave_fsm

Serial-to-parallel front end of the SPI wrapper, directly upstream of the single-port RAM. It deserialises MOSI frames into 10-bit RAM command words (`rx_data`/`rx_valid`). On a read-data frame it captures the RAM's 8-bit response (`tx_data`/`tx_valid`) and serialises it onto MISO. All logic runs on the system clock; `SS_n` and `MOSI` are sampled at `clk` rising edges.

## Interface
- `ADDR_W`, default 8: RAM address/data width; command word width is `ADDR_W+2`.
- `clk`  in  1  system clock; all sampling and updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `SS_n`  in  1  slave select, active low; a high level ends the current frame.
- `MOSI`  in  1  serial data in, MSB first.
- `tx_data`  in  8  RAM read data.
- `tx_valid`  in  1  `tx_data` valid strobe from the RAM.
- `rx_data`  out  10  command word to the RAM: `[9:8]` opcode (00 write-addr, 01 write-data, 10 read-addr, 11 read-data), `[7:0]` payload.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` valid.
- `MISO`  out  1  serial data out, MSB first.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: `SS_n`=0 -> CHK_CMD; otherwise stay.
- CHK_CMD: samples the select bit (not stored).
  - `SS_n`=1 -> IDLE.
  - MOSI=0 -> WRITE.
  - MOSI=1 and `rd_addr_seen`=0 -> READ_ADD.
  - MOSI=1 and `rd_addr_seen`=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA:
  - Shift the next 10 MOSI bits into a shift register, MSB first; a 4-bit counter runs 0..9.
  - On the 10th bit, `rx_data` is loaded and `rx_valid` pulses for exactly one cycle.
  - Opcode bits are forwarded unmodified; the block does not police opcode/state mismatches.
- READ_ADD: the `rx_valid` pulse sets `rd_addr_seen`.
- READ_DATA, after its `rx_valid` pulse:
  - Wait for `tx_valid`. On the `tx_valid` cycle, latch `tx_data` and clear `rd_addr_seen`.
  - Drive the 8 latched bits on MISO over the next 8 cycles, bit 7 first.
  - MISO then holds 0.
  - `tx_valid` outside this wait window is ignored.
- `SS_n`=1 in any non-IDLE state -> IDLE on that edge:
  - the partial word is discarded, with no `rx_valid`;
  - the counter and TX shifting abort and MISO returns to 0;
  - `rd_addr_seen` is retained.
- Reset values: state IDLE, `rx_data`=0, `rx_valid`=0, `MISO`=0, `rd_addr_seen`=0, counters 0. Reset asserted mid-frame aborts immediately, asynchronously.

## Timing
- Frame: 1 select bit + 10 payload bits = 11 clocks from the first CHK_CMD cycle.
- `rx_valid` is high in the cycle after the edge that samples the 10th payload bit, for exactly one cycle. `rx_data` holds until the next load.
- First MISO bit is driven in the cycle after the `tx_valid` edge. Each bit is held one clock; 8 clocks total.
- With RAM latency 1 (`tx_valid` the cycle after `rx_valid`), MISO bit 7 appears 2 cycles after `rx_valid`.
- Back-to-back frames require `SS_n` high for at least one sampled edge between them.
- Simultaneous `SS_n`=1 and 10th-bit edge: the abort wins and no `rx_valid` is produced.

## Structure
- Package `spi_pkg` holds:
  - the state enum (`IDLE`, `CHK_CMD`, `WRITE`, `READ_ADD`, `READ_DATA`);
  - opcode localparams `OP_WR_ADDR`=2'b00, `OP_WR_DATA`=2'b01, `OP_RD_ADDR`=2'b10, `OP_RD_DATA`=2'b11;
  - `FRAME_BITS`=10.
- One sub-module, `spi_tx_shifter`: load-on-`tx_valid`, 8-bit MSB-first shifter with busy flag and abort input. The FSM, RX shift register and counters live in `spi_slave_fsm`.

## Test plan
- Write-address frame: `SS_n` low, MOSI 0 then 00_1010_0101 -> one `rx_valid` pulse with `rx_data`=10'h0A5, state back to IDLE after `SS_n` high.
- Write-data frame: MOSI 0 then 01_1111_0000 -> `rx_data`=10'h1F0; `rd_addr_seen` stays 0.
- Read sequence:
  - Read-address frame MOSI 1 then 10_0011_1100 -> `rx_data`=10'h23C and `rd_addr_seen`=1.
  - Read-data frame MOSI 1 then 11_0000_0000 -> `rx_data`=10'h300.
  - Respond `tx_valid` with `tx_data`=8'hB6 -> MISO 1,0,1,1,0,1,1,0 on the following 8 cycles, then `rd_addr_seen`=0.
- Abort: `SS_n` raised after 5 payload bits -> no `rx_valid`, IDLE next cycle, MISO=0.
- Reset mid-transmit: assert `rst` during MISO bit 3 -> MISO=0, `rx_valid`=0, state IDLE immediately; a fresh read-data select bit routes to READ_ADD because `rd_addr_seen` is cleared.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   localparam int FRAME_BITS = 10;

endpackage

// File: rtl/spi_tx_shifter.sv
// MSB-first parallel-to-serial shifter for the RAM read response.
// The first bit appears in the cycle after load; the output idles at 0.
module spi_tx_shifter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] data,
   input  logic         abort,
   output logic         serial,
   output logic         busy
);

   localparam int CW = $clog2(W) + 1;

   logic [W-1:0]  sr;
   logic [CW-1:0] remaining;

   // Load, shift and abort handling for the serial output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr        <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         serial    <= 1'b0;
      end else if (abort) begin
         sr        <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         serial    <= 1'b0;
      end else if (load) begin
         serial    <= data[W-1];
         sr        <= {data[W-2:0], 1'b0};
         remaining <= CW'(W - 1);
         busy      <= 1'b1;
      end else if (busy) begin
         if (remaining == '0) begin
            serial <= 1'b0;
            busy   <= 1'b0;
         end else begin
            serial    <= sr[W-1];
            sr        <= {sr[W-2:0], 1'b0};
            remaining <= remaining - CW'(1);
         end
      end else begin
         serial <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises MOSI frames into RAM command words and
// serialises the RAM read response onto MISO.
module spi_slave_fsm
   import spi_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   input  logic [ADDR_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic [ADDR_W+1:0] rx_data,
   output logic              rx_valid,
   output logic              MISO
);

   localparam int WORD_W = ADDR_W + 2;

   state_t            state;
   state_t            next_state;
   logic [3:0]        cnt;
   logic [WORD_W-2:0] shift;
   logic              done;
   logic              tx_taken;
   logic              rd_addr_seen;
   logic              in_payload;
   logic              last_bit;
   logic              load_tx;
   logic              abort;
   logic              tx_busy;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus the per-cycle frame event strobes.
   always_comb begin
      next_state = state;
      in_payload = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
      abort      = in_payload && SS_n;
      // SS_n high beats a coincident 10th bit: no word is delivered.
      last_bit   = in_payload && !SS_n && !done && (cnt == 4'(WORD_W - 1));
      load_tx    = (state == READ_DATA) && !SS_n && done && !tx_taken && tx_valid;
      case (state)
         IDLE: begin
            if (!SS_n) next_state = CHK_CMD;
            else       next_state = IDLE;
         end
         CHK_CMD: begin
            if (SS_n)              next_state = IDLE;
            else if (!MOSI)        next_state = WRITE;
            else if (!rd_addr_seen) next_state = READ_ADD;
            else                   next_state = READ_DATA;
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) next_state = IDLE;
            else      next_state = state;
         end
         default: next_state = IDLE;
      endcase
   end

   // Payload shift register, bit counter and per-frame progress flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= 4'd0;
         shift    <= '0;
         done     <= 1'b0;
         tx_taken <= 1'b0;
      end else if (!in_payload || SS_n) begin
         cnt      <= 4'd0;
         shift    <= '0;
         done     <= 1'b0;
         tx_taken <= 1'b0;
      end else if (!done) begin
         shift <= {shift[WORD_W-3:0], MOSI};
         if (cnt == 4'(WORD_W - 1)) begin
            cnt  <= 4'd0;
            done <= 1'b1;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end else if (load_tx) begin
         tx_taken <= 1'b1;
      end else begin
         tx_taken <= tx_taken;
      end
   end

   // Command word output and its one-cycle strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= last_bit;
         if (last_bit) begin
            rx_data <= {shift, MOSI};
         end else begin
            rx_data <= rx_data;
         end
      end
   end

   // Read-address bookkeeping; survives SS_n aborts, cleared by the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr_seen <= 1'b0;
      end else if (last_bit && (state == READ_ADD)) begin
         rd_addr_seen <= 1'b1;
      end else if (load_tx) begin
         rd_addr_seen <= 1'b0;
      end else begin
         rd_addr_seen <= rd_addr_seen;
      end
   end

   spi_tx_shifter #(
      .W (ADDR_W)
   ) u_tx (
      .clk    (clk),
      .rst    (rst),
      .load   (load_tx),
      .data   (tx_data),
      .abort  (abort),
      .serial (MISO),
      .busy   (tx_busy)
   );

endmodule
